// File: rtl/warships_pkg.sv
// Shared definitions for the warships display logic: blink states,
// active-low seven-segment codes and digit-split helpers.
package warships_pkg;

  typedef enum logic {
    VISIBLE = 1'b0,
    HIDDEN  = 1'b1
  } blink_state_t;

  // Segment codes are active-low, bit order g..a (seg[6]=g, seg[0]=a)
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // A 4-bit value never exceeds 15, so its tens digit is only ever 0 or 1
  function automatic logic [3:0] tens_of(input logic [3:0] value);
    return (value >= 4'd10) ? 4'd1 : 4'd0;
  endfunction

  function automatic logic [3:0] units_of(input logic [3:0] value);
    return value - ((value >= 4'd10) ? 4'd10 : 4'd0);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Codes above 9 decode to a blank digit.
module seg7_decoder (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  import warships_pkg::*;

  // Look up the segment pattern for the requested digit
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_disp.sv
// Four-digit multiplexed score display: own ships on the left pair of
// digits, enemy ships on the right pair, whole display blinking once the
// game has ended. Inputs are sampled once per full scan so a scan is
// always self-consistent.
module score_disp #(
  parameter int REFRESH_CYCLES = 25000,
  parameter int BLINK_FRAMES   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] my_ctr,
  input  logic [3:0] en_ctr,
  input  logic       game_end,
  output logic [6:0] seg,
  output logic [3:0] an
);
  import warships_pkg::*;

  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    slot;
  logic [FW-1:0] frame_cnt;
  logic [FW-1:0] frame_next;
  logic [3:0]    snap_my;
  logic [3:0]    snap_en;
  logic          snap_end;
  blink_state_t  state;
  blink_state_t  state_next;

  logic          terminal;
  logic          wrap;
  logic [3:0]    digit;
  logic          blank;
  logic [6:0]    dec_seg;

  assign terminal = (refresh_cnt == RW'(REFRESH_CYCLES - 1));
  assign wrap     = terminal && (slot == 2'd3);

  // Refresh timer, slot rotation and once-per-scan input snapshot
  always_ff @(posedge clk) begin
    if (!rst) begin
      refresh_cnt <= '0;
      slot        <= 2'd0;
      snap_my     <= 4'd0;
      snap_en     <= 4'd0;
      snap_end    <= 1'b0;
    end else begin
      refresh_cnt <= terminal ? '0 : refresh_cnt + 1'b1;
      if (terminal) begin
        slot <= slot + 2'd1;
      end
      if (wrap) begin
        snap_my  <= my_ctr;
        snap_en  <= en_ctr;
        snap_end <= game_end;
      end
    end
  end

  // Blink state and frame counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= VISIBLE;
      frame_cnt <= '0;
    end else begin
      state     <= state_next;
      frame_cnt <= frame_next;
    end
  end

  // Blink next-state: only scans completed under a latched game_end count,
  // and a newly latched game_end=0 forces the display back on immediately
  always_comb begin
    state_next = state;
    frame_next = frame_cnt;
    if (wrap) begin
      if (!game_end) begin
        state_next = VISIBLE;
        frame_next = '0;
      end else if (snap_end) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          state_next = (state == VISIBLE) ? HIDDEN : VISIBLE;
          frame_next = '0;
        end else begin
          frame_next = frame_cnt + 1'b1;
        end
      end
    end
  end

  // Select the digit for the active slot; tens slots blank on a zero digit
  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    unique case (slot)
      2'd0: digit = units_of(snap_en);
      2'd1: begin
        digit = tens_of(snap_en);
        blank = (digit == 4'd0);
      end
      2'd2: digit = units_of(snap_my);
      2'd3: begin
        digit = tens_of(snap_my);
        blank = (digit == 4'd0);
      end
    endcase
  end

  seg7_decoder u_decoder (
    .digit (digit),
    .seg   (dec_seg)
  );

  // Registered anode and segment drive
  always_ff @(posedge clk) begin
    if (!rst) begin
      an  <= 4'hF;
      seg <= SEG_BLANK;
    end else if (state == HIDDEN || blank) begin
      an  <= 4'hF;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << slot);
      seg <= dec_seg;
    end
  end

endmodule

// File: tb/tb_score_disp.sv
// Scoreboard bench for score_disp: two instances (slow scan with blinking
// every 2 scans, and one-cycle slots with blinking every scan) share the
// same stimulus; a scan-level reference model predicts each cycle's output.
module tb_score_disp;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  localparam int RA = 4;
  localparam int BA = 2;
  localparam int RB = 1;
  localparam int BB = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] my_ctr;
  logic [3:0] en_ctr;
  logic       game_end;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;

  exp_t qa[$];
  exp_t qb[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, one entry per instance
  int         t_cnt [2];
  logic [3:0] s_my  [2];
  logic [3:0] s_en  [2];
  logic       s_end [2];
  int         run_n [2];
  logic       hid   [2];

  score_disp #(.REFRESH_CYCLES(RA), .BLINK_FRAMES(BA)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .my_ctr   (my_ctr),
    .en_ctr   (en_ctr),
    .game_end (game_end),
    .seg      (seg_a),
    .an       (an_a)
  );

  score_disp #(.REFRESH_CYCLES(RB), .BLINK_FRAMES(BB)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .my_ctr   (my_ctr),
    .en_ctr   (en_ctr),
    .game_end (game_end),
    .seg      (seg_b),
    .an       (an_b)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit_code(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // One clock edge of the reference model: t counts edges since reset,
  // slot = (t / R) % 4, a scan is 4R cycles, snapshot changes at scan ends.
  // Hidden iff the latched game_end is 1 and the number n of completed
  // game_end scans before this one satisfies (n / B) odd.
  task automatic model_step(input int i, input int r, input int b,
                            output exp_t e);
    int slot, val, dig;
    bit blk;
    if (!rst) begin
      e.an = 4'hF;
      e.seg = 7'h7F;
      t_cnt[i] = 0;
      s_my[i] = 4'd0;
      s_en[i] = 4'd0;
      s_end[i] = 1'b0;
      run_n[i] = 0;
      hid[i] = 1'b0;
      return;
    end
    slot = (t_cnt[i] / r) % 4;
    val  = (slot >= 2) ? int'(s_my[i]) : int'(s_en[i]);
    dig  = (slot % 2 == 0) ? val % 10 : val / 10;
    blk  = (slot % 2 == 1) && (dig == 0);
    if (hid[i] || blk) begin
      e.an = 4'hF;
      e.seg = 7'h7F;
    end else begin
      e.an = ~(4'b0001 << slot);
      e.seg = digit_code(dig);
    end
    if (t_cnt[i] % (4 * r) == 4 * r - 1) begin
      if (game_end) run_n[i] = s_end[i] ? run_n[i] + 1 : 0;
      else run_n[i] = 0;
      hid[i]   = game_end && (((run_n[i] / b) % 2) == 1);
      s_my[i]  = my_ctr;
      s_en[i]  = en_ctr;
      s_end[i] = game_end;
    end
    t_cnt[i]++;
  endtask

  // Predict each instance's output for this edge and queue it
  always @(posedge clk) begin
    exp_t ea, eb;
    model_step(0, RA, BA, ea);
    model_step(1, RB, BB, eb);
    qa.push_back(ea);
    qb.push_back(eb);
  end

  task automatic check_output(input string name, input exp_t e,
                              input logic [3:0] an_v, input logic [6:0] seg_v);
    vectors++;
    if (an_v !== e.an || seg_v !== e.seg) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got an=%b seg=%b, expected an=%b seg=%b",
               name, $time, an_v, seg_v, e.an, e.seg);
    end
  endtask

  // Monitor: compare registered outputs on the falling edge
  always @(negedge clk) begin
    if (qa.size() > 0) check_output("dut_a", qa.pop_front(), an_a, seg_a);
    if (qb.size() > 0) check_output("dut_b", qb.pop_front(), an_b, seg_b);
  end

  task automatic apply_stimulus(input logic r, input logic [3:0] m,
                                input logic [3:0] e, input logic g, input int n);
    rst = r;
    my_ctr = m;
    en_ctr = e;
    game_end = g;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int rst_hold;
    rst = 1'b0;
    my_ctr = 4'd0;
    en_ctr = 4'd0;
    game_end = 1'b0;
    rst_hold = 0;

    $display("[TB] start");
    apply_stimulus(1'b0, 4'd0, 4'd0, 1'b0, 3);
    // Scan of 7 / 12, then a mid-scan change of my_ctr
    apply_stimulus(1'b1, 4'd7, 4'd12, 1'b0, 48);
    apply_stimulus(1'b1, 4'd7, 4'd12, 1'b0, 5);
    apply_stimulus(1'b1, 4'd10, 4'd12, 1'b0, 40);
    // Blinking, then game_end released
    apply_stimulus(1'b1, 4'd10, 4'd12, 1'b1, 160);
    apply_stimulus(1'b1, 4'd10, 4'd12, 1'b0, 40);
    // Reset asserted mid-scan and mid-blink
    apply_stimulus(1'b1, 4'd3, 4'd4, 1'b1, 57);
    apply_stimulus(1'b0, 4'd3, 4'd4, 1'b1, 2);
    apply_stimulus(1'b1, 4'd3, 4'd4, 1'b0, 20);
    // Maximum counter values
    apply_stimulus(1'b1, 4'd15, 4'd15, 1'b0, 40);

    // Randomized run with slowly varying game_end and rare resets
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) my_ctr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) en_ctr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) game_end = ~game_end;
      if (rst_hold > 0) begin
        rst = 1'b0;
        rst_hold--;
      end else begin
        rst = 1'b1;
        if ($urandom_range(0, 399) == 0) rst_hold = $urandom_range(1, 3);
      end
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    #1;
    if (qa.size() != 0 || qb.size() != 0 || vectors == 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d/%0d entries pending, %0d vectors checked",
               qa.size(), qb.size(), vectors);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/score_disp.md
SCORE_DISP -- requirements
Module: score_disp

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 25000: clk cycles per digit slot; legal range >= 1.
REQ-002 SHALL have parameter BLINK_FRAMES, default 64: full 4-digit scans per blink half-period; legal range >= 1.
REQ-003 SHALL have port clk  input  1  single clock (control_clk domain); all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset; rst=0 sampled on a clk edge resets the block.
REQ-005 SHALL have port my_ctr  input  4  remaining own ships, unsigned 0..15.
REQ-006 SHALL have port en_ctr  input  4  remaining enemy ships, unsigned 0..15.
REQ-007 SHALL have port game_end  input  1  level; 1 = game finished, display blinks.
REQ-008 SHALL have port seg  output  7  active-low segments; seg[0]=a ... seg[6]=g.
REQ-009 SHALL have port an  output  4  active-low digit enables; an[0] = rightmost digit.

Function
REQ-010 SHALL map digit slots as: slot 3 = my_ctr tens, slot 2 = my_ctr units, slot 1 = en_ctr tens, slot 0 = en_ctr units.
REQ-011 SHALL compute tens = (value >= 10) ? 1 : 0 and units = value - 10*tens, for 4-bit values only.
REQ-012 SHALL blank a tens slot (an bit held 1) when its tens digit is 0; units slots are never zero-blanked.
REQ-013 SHALL run a refresh counter 0..REFRESH_CYCLES-1; at terminal count, counter returns to 0 and slot index advances 0->1->2->3->0.
REQ-014 SHALL, when REFRESH_CYCLES=1, advance the slot index every clk cycle.
REQ-015 SHALL snapshot my_ctr, en_ctr and game_end into internal registers only on the 3->0 slot wrap, so that one scan never mixes old and new values.
REQ-016 SHALL register seg and an; outputs reflect current slot index and snapshot one clk after the index changes.
REQ-017 SHALL drive exactly one an bit low per cycle when display is visible; all other an bits are 1.
REQ-018 SHALL encode digits active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000 (bits g..a).
REQ-019 SHALL drive seg=1111111 whenever the active slot is blanked or the display is hidden.
REQ-020 SHALL implement a two-state blink FSM: VISIBLE, HIDDEN.
REQ-021 SHALL, while snapshot game_end=1, count completed scans; after BLINK_FRAMES wraps, toggle VISIBLE<->HIDDEN and clear the frame counter.
REQ-022 SHALL, in HIDDEN, hold an=1111 and seg=1111111 while the scan counters keep running.
REQ-023 SHALL, on a wrap where snapshot game_end becomes 0, enter VISIBLE and clear the frame counter in that same cycle.
REQ-024 SHALL, when input changes and wrap coincide in one cycle, capture the new value on that edge.

Reset
REQ-025 SHALL, on reset, set refresh counter=0, slot index=0, frame counter=0, FSM=VISIBLE, snapshot=0, an=1111, seg=1111111.
REQ-026 SHALL, on the first cycle after rst returns to 1, show slot 0 with value 0: an=1110, seg=1000000.
REQ-027 SHALL abort any scan or blink in progress when reset is asserted mid-operation; no output state is retained.

Structure
REQ-028 SHALL take segment encodings, the SEG_BLANK constant (7'h7F) and the blink-state enum from the shared package warships_pkg.
REQ-029 SHALL instantiate one combinational sub-module seg7_decoder (4-bit digit in, 7-bit active-low segments out).

Verification
REQ-030 SHALL verify, with REFRESH_CYCLES=4, my_ctr=7, en_ctr=12: an sequence 1110, 1101, (slot 2) 1011, slot 3 blanked (1111); seg = 2, 1, 7, blank; each slot held 4 cycles.
REQ-031 SHALL verify that changing my_ctr 7->10 mid-scan keeps 7 until the next 3->0 wrap; the following scan shows slot 3=1 and slot 2=0.
REQ-032 SHALL verify, with BLINK_FRAMES=2 and game_end=1, that the display toggles between hidden (an=1111) and visible every 2 scans (32 cycles); game_end=0 restores VISIBLE at the next wrap.
REQ-033 SHALL verify that rst=0 asserted mid-scan forces an=1111, seg=1111111 on the next edge, and that release yields an=1110, seg=1000000.
REQ-034 SHALL verify, with REFRESH_CYCLES=1 and my_ctr=en_ctr=15, that the slot index advances every cycle and segments show 5, 1, 5, 1 for slots 0..3.
